// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S slave receiver.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_HOLD
    } i2s_rx_state_t;

    localparam int SAMPLE_BITS_DEFAULT = 24;
    localparam int FRAME_BITS          = 2 * SAMPLE_BITS_DEFAULT;

    // LRCK level that marks the left channel.
    localparam logic LEFT_LRCK = 1'b0;

endpackage

// File: rtl/i2s_fifo_if.sv
// Producer/consumer handshake carrying one stereo pair per transfer.
interface FIFOInterface #(
    parameter int WIDTH = i2s_pkg::FRAME_BITS
);
    logic             enable;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport out (output enable, output data, input ready);
    modport in  (input enable, input data, output ready);
endinterface

// File: rtl/i2s_input_sync.sv
// Synchronizes one asynchronous I2S pin into clk and produces level plus
// single-cycle rise/fall strobes.
module i2s_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync[0] <= pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCK/LRCK/SDATA on clk, deserializes
// left/right words and offers each stereo pair on a FIFO producer port.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
    parameter int DATA_DELAY  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bck,
    input  logic         lrck,
    input  logic         sdata,
    FIFOInterface.out    samples,
    output logic         overrun,
    output logic         frame_error
);

    localparam int CW  = $clog2(SAMPLE_BITS + 1);
    localparam int DCW = (DATA_DELAY > 1) ? $clog2(DATA_DELAY + 1) : 1;

    logic bck_rise, bck_level_unused, bck_fall_unused;
    logic lrck_level, lrck_rise, lrck_fall;
    logic sd_level, sd_rise_unused, sd_fall_unused;

    i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
        .clk(clk), .reset(reset), .pin(bck),
        .level(bck_level_unused), .rise(bck_rise), .fall(bck_fall_unused)
    );

    i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .reset(reset), .pin(lrck),
        .level(lrck_level), .rise(lrck_rise), .fall(lrck_fall)
    );

    i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(clk), .reset(reset), .pin(sdata),
        .level(sd_level), .rise(sd_rise_unused), .fall(sd_fall_unused)
    );

    i2s_rx_state_t          state;
    logic                   ch;
    logic [CW-1:0]          bit_cnt;
    logic [DCW-1:0]         dly_cnt;
    logic                   lr_pend;
    logic [SAMPLE_BITS-1:0] left_sr;
    logic [SAMPLE_BITS-1:0] right_sr;

    logic          boundary;
    logic          start;
    logic          start_ch;
    logic          frame_bad;
    logic          capture;
    logic          cap_ch;
    logic [CW-1:0] cnt_base;
    logic          last_bit;
    logic          pair_now;

    // LRCK edges are held until the next BCK rise, which decides the boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_pend <= 1'b0;
        end else if (bck_rise) begin
            lr_pend <= 1'b0;
        end else if (lrck_rise || lrck_fall) begin
            lr_pend <= 1'b1;
        end
    end

    assign boundary = bck_rise & (lr_pend | lrck_rise | lrck_fall);

    always_comb begin
        start    = 1'b0;
        start_ch = ch;
        if (boundary) begin
            case (state)
                ST_IDLE: begin
                    if (lrck_level == LEFT_LRCK) begin
                        start    = 1'b1;
                        start_ch = LEFT_LRCK;
                    end
                end
                ST_HOLD: begin
                    if (lrck_level != ch) begin
                        start    = 1'b1;
                        start_ch = lrck_level;
                    end
                end
                default: ;
            endcase
        end
        frame_bad = boundary && (state == ST_DELAY || state == ST_SHIFT ||
                                 (state == ST_HOLD && !start));
        capture   = (bck_rise && state == ST_SHIFT && !boundary) ||
                    (start && DATA_DELAY == 0);
        cap_ch    = start ? start_ch : ch;
        cnt_base  = start ? '0 : bit_cnt;
        last_bit  = capture && (cnt_base == CW'(SAMPLE_BITS - 1));
        pair_now  = last_bit && (cap_ch != LEFT_LRCK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ch          <= LEFT_LRCK;
            bit_cnt     <= '0;
            dly_cnt     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= frame_bad;
            if (frame_bad) begin
                state <= ST_IDLE;
            end else if (start) begin
                ch      <= start_ch;
                bit_cnt <= capture ? CW'(1) : '0;
                if (DATA_DELAY == 0) begin
                    state <= last_bit ? ST_HOLD : ST_SHIFT;
                end else if (DATA_DELAY == 1) begin
                    state <= ST_SHIFT;
                end else begin
                    state   <= ST_DELAY;
                    dly_cnt <= DCW'(1);
                end
            end else if (bck_rise) begin
                case (state)
                    ST_DELAY: begin
                        if (dly_cnt == DCW'(DATA_DELAY - 1)) begin
                            state <= ST_SHIFT;
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state <= ST_HOLD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel shift registers; stale contents are always overwritten by a full word.
    always_ff @(posedge clk) begin
        if (capture) begin
            if (cap_ch == LEFT_LRCK) begin
                left_sr <= {left_sr[SAMPLE_BITS-2:0], sd_level};
            end else begin
                right_sr <= {right_sr[SAMPLE_BITS-2:0], sd_level};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samples.enable <= 1'b0;
            samples.data   <= '0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pair_now) begin
                if (!samples.enable || samples.ready) begin
                    samples.data   <= {left_sr, right_sr[SAMPLE_BITS-2:0], sd_level};
                    samples.enable <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (samples.enable && samples.ready) begin
                samples.enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: one I2S (delay 1) and one
// left-justified (delay 0) instance share the serial pins.
module tb_i2s_receiver;

    logic clk = 1'b0;
    logic reset;
    logic bck, lrck, sdata;
    logic ovr1, fe1, ovr0, fe0;

    FIFOInterface #(.WIDTH(48)) s1();
    FIFOInterface #(.WIDTH(48)) s0();

    always #5 clk = ~clk;

    i2s_receiver #(.SAMPLE_BITS(24), .DATA_DELAY(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .sdata(sdata),
        .samples(s1), .overrun(ovr1), .frame_error(fe1)
    );

    i2s_receiver #(.SAMPLE_BITS(24), .DATA_DELAY(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .sdata(sdata),
        .samples(s0), .overrun(ovr0), .frame_error(fe0)
    );

    int checks = 0;
    int errors = 0;
    logic [47:0] q1[$];
    logic [47:0] q0[$];
    bit chk1 = 1'b0;
    bit chk0 = 1'b0;
    int xfer1, xfer0, ovr_cnt1, ovr_cnt0, fe_cnt1, fe_cnt0;

    task automatic check(input string nm, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: pops expected pairs on every handshake, tallies flag pulses.
    initial begin
        logic [47:0] exp;
        forever begin
            @(negedge clk);
            if (chk1 && s1.enable && s1.ready) begin
                xfer1++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected got %h expected none", s1.data);
                end else begin
                    exp = q1.pop_front();
                    if (s1.data !== exp) begin
                        errors++;
                        $display("FAIL dut1_data got %h expected %h", s1.data, exp);
                    end
                end
            end
            if (chk0 && s0.enable && s0.ready) begin
                xfer0++;
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0_unexpected got %h expected none", s0.data);
                end else begin
                    exp = q0.pop_front();
                    if (s0.data !== exp) begin
                        errors++;
                        $display("FAIL dut0_data got %h expected %h", s0.data, exp);
                    end
                end
            end
            if (chk1 && ovr1) ovr_cnt1++;
            if (chk1 && fe1)  fe_cnt1++;
            if (chk0 && ovr0) ovr_cnt0++;
            if (chk0 && fe0)  fe_cnt0++;
        end
    end

    // One BCK period = 8 clk; LRCK and SDATA change on the falling BCK edge.
    task automatic bck_cycle(input logic lr, input logic sd);
        bck   = 1'b0;
        lrck  = lr;
        sdata = sd;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic slot_bit(input logic [23:0] w, input int j, input int dd);
        int idx;
        idx = 23 - (j - dd);
        if (idx >= 0 && idx <= 23) return w[idx];
        return 1'b0;
    endfunction

    task automatic send_half(input logic lr, input logic [23:0] w, input int dd,
                             input int first, input int last);
        for (int j = first; j <= last; j++) bck_cycle(lr, slot_bit(w, j, dd));
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int dd);
        send_half(1'b0, l, dd, 0, 31);
        send_half(1'b1, r, dd, 0, 31);
    endtask

    task automatic idle(input int n);
        repeat (n) bck_cycle(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic zero_counts();
        xfer1 = 0; xfer0 = 0; ovr_cnt1 = 0; ovr_cnt0 = 0; fe_cnt1 = 0; fe_cnt0 = 0;
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("dut1_pending", 48'(q1.size()), 48'd0);
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("dut0_pending", 48'(q0.size()), 48'd0);
    endtask

    initial begin
        reset = 1'b1;
        bck   = 1'b1;
        lrck  = 1'b1;
        sdata = 1'b0;
        s1.ready = 1'b1;
        s0.ready = 1'b1;
        zero_counts();
        repeat (3) @(negedge clk);
        check("rst_enable", 48'(s1.enable), 48'd0);
        check("rst_data", s1.data, 48'd0);
        check("rst_overrun", 48'(ovr1), 48'd0);
        check("rst_frame_error", 48'(fe1), 48'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Nominal stream, two identical frames.
        chk1 = 1'b1;
        zero_counts();
        idle(4);
        q1.push_back(48'hA5A5A5_123456);
        q1.push_back(48'hA5A5A5_123456);
        send_frame(24'hA5A5A5, 24'h123456, 1);
        send_frame(24'hA5A5A5, 24'h123456, 1);
        drain1();
        check("nominal_xfers", 48'(xfer1), 48'd2);
        check("nominal_overrun", 48'(ovr_cnt1), 48'd0);
        check("nominal_frame_error", 48'(fe_cnt1), 48'd0);

        // Start in the middle of a right half-frame.
        do_reset();
        zero_counts();
        idle(2);
        send_half(1'b1, 24'hFFFFFF, 1, 12, 31);
        q1.push_back(48'h111111_222222);
        send_frame(24'h111111, 24'h222222, 1);
        drain1();
        check("midright_xfers", 48'(xfer1), 48'd1);
        check("midright_frame_error", 48'(fe_cnt1), 48'd0);

        // Consumer stalls across three frames.
        do_reset();
        zero_counts();
        idle(2);
        @(posedge clk);
        #2 s1.ready = 1'b0;
        q1.push_back(48'h000001_00000A);
        send_frame(24'h000001, 24'h00000A, 1);
        send_frame(24'h000002, 24'h00000B, 1);
        send_frame(24'h000003, 24'h00000C, 1);
        check("stall_overrun", 48'(ovr_cnt1), 48'd2);
        check("stall_xfers", 48'(xfer1), 48'd0);
        check("stall_enable", 48'(s1.enable), 48'd1);
        @(posedge clk);
        #2 s1.ready = 1'b1;
        drain1();
        check("stall_release_xfers", 48'(xfer1), 48'd1);
        check("stall_frame_error", 48'(fe_cnt1), 48'd0);

        // Short left word (10 bits) then a good frame.
        do_reset();
        zero_counts();
        idle(2);
        send_half(1'b0, 24'h3C3C3C, 1, 0, 10);
        send_half(1'b1, 24'h0F0F0F, 1, 0, 31);
        q1.push_back(48'h654321_0ABCDE);
        send_frame(24'h654321, 24'h0ABCDE, 1);
        drain1();
        check("short_frame_error", 48'(fe_cnt1), 48'd1);
        check("short_xfers", 48'(xfer1), 48'd1);

        // Left-justified instance, MSB on the boundary rise.
        chk1 = 1'b0;
        do_reset();
        chk0 = 1'b1;
        zero_counts();
        idle(2);
        q0.push_back(48'h800001_7FFFFE);
        send_frame(24'h800001, 24'h7FFFFE, 0);
        drain0();
        check("lj_xfers", 48'(xfer0), 48'd1);
        check("lj_frame_error", 48'(fe_cnt0), 48'd0);
        chk0 = 1'b0;

        // Reset during a right word while a pair is pending.
        do_reset();
        chk1 = 1'b1;
        zero_counts();
        idle(2);
        @(posedge clk);
        #2 s1.ready = 1'b0;
        send_frame(24'hABCDEF, 24'h135791, 1);
        send_half(1'b0, 24'h111111, 1, 0, 31);
        send_half(1'b1, 24'h222222, 1, 0, 10);
        check("prereset_enable", 48'(s1.enable), 48'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_enable", 48'(s1.enable), 48'd0);
        check("midreset_data", s1.data, 48'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        s1.ready = 1'b1;
        idle(2);
        q1.push_back(48'h2468AC_FDB975);
        send_frame(24'h2468AC, 24'hFDB975, 1);
        drain1();
        check("postreset_xfers", 48'(xfer1), 48'd1);
        check("postreset_overrun", 48'(ovr_cnt1), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
